// File: rtl/legv8_mc_ctrl.sv
// Multicycle LEGv8 control FSM: decodes the IR opcode, sequences FETCH/DECODE/EXEC/MEM/WB
// with bounded memory wait-states. Optional retired-instruction counter under LEGV8_RETIRE_CNT_EN.
module legv8_mc_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_branch,
   output logic        pc_uncond,
   output logic        reg2_loc,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        illegal,
   output logic        err,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
   typedef enum logic [2:0] {C_NONE, C_R, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_B} class_t;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state, state_next;
   class_t           cls, dec_cls;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             waiting;

   always_comb begin
      dec_cls = C_NONE;
      casez (opcode)
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: dec_cls = C_R;
         11'b1001000100?: dec_cls = C_ADDI;
         11'b11111000010: dec_cls = C_LDUR;
         11'b11111000000: dec_cls = C_STUR;
         11'b10110100???: dec_cls = C_CBZ;
         11'b000101?????: dec_cls = C_B;
         default:         dec_cls = C_NONE;
      endcase
   end

   // The wait that would make the count reach MEM_TIMEOUT diverts to ERR instead.
   assign timeout_hit = (wait_cnt == WAIT_LAST);
   assign waiting     = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         cls      <= C_NONE;
         wait_cnt <= '0;
         illegal  <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE)
            cls <= dec_cls;
         if (state_next != state)
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + 1'b1;
         if ((state == S_DECODE) && (dec_cls == C_NONE))
            illegal <= 1'b1;
         if ((state != S_ERR) && (state_next == S_ERR))
            err <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: begin
            if (imem_ready)
               state_next = S_DECODE;
            else if (timeout_hit)
               state_next = S_ERR;
         end
         S_DECODE: state_next = (dec_cls == C_NONE) ? S_FETCH : S_EXEC;
         S_EXEC: begin
            case (cls)
               C_R, C_ADDI:    state_next = S_WB;
               C_LDUR, C_STUR: state_next = S_MEM;
               default:        state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)
               state_next = (cls == C_LDUR) ? S_WB : S_FETCH;
            else if (timeout_hit)
               state_next = S_ERR;
         end
         S_WB:    state_next = S_FETCH;
         S_ERR:   state_next = S_ERR;
         default: state_next = S_FETCH;
      endcase
   end

   // Reset gates every strobe so nothing stays asserted while reset is high.
   always_comb begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_branch  = 1'b0;
      pc_uncond  = 1'b0;
      reg2_loc   = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      if (!reset) begin
         if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
            reg2_loc = (cls == C_STUR) || (cls == C_CBZ);
            case (cls)
               C_R:                    alu_op  = 2'b10;
               C_ADDI, C_LDUR, C_STUR: alu_src = 1'b1;
               C_CBZ:                  alu_op  = 2'b01;
               default: ;
            endcase
         end
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
               pc_write = imem_ready;
            end
            S_DECODE: reg2_loc = (dec_cls == C_STUR) || (dec_cls == C_CBZ);
            S_EXEC: begin
               pc_branch = (cls == C_CBZ);
               pc_uncond = (cls == C_B);
            end
            S_MEM: begin
               mem_read  = (cls == C_LDUR);
               mem_write = (cls == C_STUR);
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls == C_LDUR);
            end
            default: ;
         endcase
      end
   end

`ifdef LEGV8_RETIRE_CNT_EN
   logic retire_evt;

   assign retire_evt = (state == S_WB) ||
                       ((state == S_MEM) && (cls == C_STUR) && dmem_ready) ||
                       ((state == S_EXEC) && ((cls == C_CBZ) || (cls == C_B)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired <= 32'd0;
      else if (retire_evt)
         retired <= retired + 32'd1;
   end
`else
   assign retired = 32'd0;
`endif

endmodule
